sequence_generator: RTL and testbench

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

---
 rtl/sequence_generator.sv | 175 +++++++++++++++++
 tb/tb_sequence_generator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_generator.sv
// Serial pattern generator: emits pattern[len]..pattern[0] MSB-first, single-shot or repeating with optional gap.
// Optional frame counter enabled by defining SEQGEN_FRAME_COUNT_EN.
module sequence_generator (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] pattern,
  input  logic [2:0] len,
  input  logic [1:0] mode,
  input  logic [3:0] gap,
  input  logic       stop,
  output logic       data,
  output logic       valid,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10
  } state_t;

  state_t     r_state;
  logic [7:0] r_pattern;
  logic [2:0] r_len;
  logic       r_repeat;
  logic       r_useGap;
  logic [3:0] r_gap;
  logic [2:0] r_bitIdx;
  logic [3:0] r_gapCnt;
  logic       r_stop;
  logic       r_data;
  logic       r_valid;
  logic       r_busy;
  logic       r_frameDone;

  logic       w_stopNow;
  logic       w_repeatReq;
  logic       w_gapReq;
  logic [2:0] w_nextIdx;

  // Mode 11 folds into single-shot; mode 10 with a zero gap folds into back-to-back.
  assign w_repeatReq = (mode == 2'b01) || (mode == 2'b10);
  assign w_gapReq    = (mode == 2'b10) && (gap != 4'd0);
  assign w_stopNow   = r_stop | stop;
  assign w_nextIdx   = r_bitIdx - 3'd1;

  // r_bitIdx always names the bit currently on the output, so the last bit is r_bitIdx == 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_pattern   <= 8'd0;
      r_len       <= 3'd0;
      r_repeat    <= 1'b0;
      r_useGap    <= 1'b0;
      r_gap       <= 4'd0;
      r_bitIdx    <= 3'd0;
      r_gapCnt    <= 4'd0;
      r_stop      <= 1'b0;
      r_data      <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      case (r_state)
        IDLE: begin
          r_data  <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_stop  <= 1'b0;
          if (start) begin
            r_pattern   <= pattern;
            r_len       <= len;
            r_repeat    <= w_repeatReq;
            r_useGap    <= w_gapReq;
            r_gap       <= gap;
            r_bitIdx    <= len;
            r_state     <= SEND;
            r_data      <= pattern[len];
            r_valid     <= 1'b1;
            r_busy      <= 1'b1;
            r_frameDone <= (len == 3'd0);
          end
        end

        SEND: begin
          r_stop <= w_stopNow;
          if (r_bitIdx != 3'd0) begin
            r_bitIdx    <= w_nextIdx;
            r_data      <= r_pattern[w_nextIdx];
            r_valid     <= 1'b1;
            r_busy      <= 1'b1;
            r_frameDone <= (w_nextIdx == 3'd0);
          end else if (w_stopNow || !r_repeat) begin
            r_state <= IDLE;
            r_stop  <= 1'b0;
            r_data  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_useGap) begin
            r_state  <= GAP;
            r_gapCnt <= r_gap - 4'd1;
            r_data   <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b1;
          end else begin
            r_bitIdx    <= r_len;
            r_data      <= r_pattern[r_len];
            r_valid     <= 1'b1;
            r_busy      <= 1'b1;
            r_frameDone <= (r_len == 3'd0);
          end
        end

        GAP: begin
          if (w_stopNow) begin
            r_state <= IDLE;
            r_stop  <= 1'b0;
            r_data  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_gapCnt == 4'd0) begin
            r_state     <= SEND;
            r_bitIdx    <= r_len;
            r_data      <= r_pattern[r_len];
            r_valid     <= 1'b1;
            r_busy      <= 1'b1;
            r_frameDone <= (r_len == 3'd0);
          end else begin
            r_gapCnt <= r_gapCnt - 4'd1;
            r_data   <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_stop  <= 1'b0;
          r_data  <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign busy       = r_busy;
  assign frame_done = r_frameDone;

`ifdef SEQGEN_FRAME_COUNT_EN
  logic [7:0] r_frameCount;

  // Counts the cycle after each frame_done pulse; an accepted start clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frameCount <= 8'd0;
    end else if ((r_state == IDLE) && start) begin
      r_frameCount <= 8'd0;
    end else if (r_frameDone && (r_frameCount != 8'hFF)) begin
      r_frameCount <= r_frameCount + 8'd1;
    end
  end

  assign frame_count = r_frameCount;
`else
  assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: vector table plus hand-written reset, restart and loopback sequences.
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic [2:0] len;
  logic [1:0] mode;
  logic [3:0] gap;
  logic       stop;
  logic       data;
  logic       valid;
  logic       busy;
  logic       frame_done;
  logic [7:0] frame_count;

  int checks = 0;
  int failures = 0;

`ifdef SEQGEN_FRAME_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  typedef struct {
    logic       st;
    logic [7:0] pat;
    logic [2:0] ln;
    logic [1:0] md;
    logic [3:0] gp;
    logic       sp;
    logic [3:0] expOut;
    logic       chkCnt;
    logic [7:0] expCnt;
  } vec_t;

  vec_t vecs[$];

  sequence_generator dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .len        (len),
    .mode       (mode),
    .gap        (gap),
    .stop       (stop),
    .data       (data),
    .valid      (valid),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] fc(input int n);
    return CntEn ? n[7:0] : 8'd0;
  endfunction

  function automatic vec_t mk(input logic st, input logic [7:0] pat, input logic [2:0] ln,
                              input logic [1:0] md, input logic [3:0] gp, input logic sp,
                              input logic [3:0] e, input logic cc, input logic [7:0] ec);
    vec_t v;
    v.st = st; v.pat = pat; v.ln = ln; v.md = md; v.gp = gp; v.sp = sp;
    v.expOut = e; v.chkCnt = cc; v.expCnt = ec;
    return v;
  endfunction

  // Busy-cycle filler whose fields differ from every captured configuration.
  function automatic vec_t nop(input logic sp, input logic [3:0] e);
    return mk(1'b0, 8'h00, 3'd7, 2'b00, 4'd0, sp, e, 1'b0, 8'd0);
  endfunction

  task automatic applyStimulus(input logic st, input logic [7:0] pat, input logic [2:0] ln,
                               input logic [1:0] md, input logic [3:0] gp, input logic sp);
    start = st; pattern = pat; len = ln; mode = md; gap = gp; stop = sp;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {data, valid, busy, frame_done};
  endfunction

  initial begin
    logic [7:0] patB4;
    logic [4:0] detShift;
    int         detCount;
    int         firstDet;
    logic [4:0] stream;

    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 3'd0, 2'b00, 4'd0, 1'b0);
    #2;
    checkOutput("reset_outputs", {28'd0, outs()}, 32'h0);
    checkOutput("reset_count", {24'd0, frame_count}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Encoding of expOut: {data, valid, busy, frame_done}
    // Single shot 8'h15 len 4 -> 1,0,1,0,1
    vecs.push_back(mk(1'b1, 8'h15, 3'd4, 2'b00, 4'd0, 1'b0, 4'b1110, 1'b0, 8'd0));
    vecs.push_back(nop(1'b0, 4'b0110));
    vecs.push_back(nop(1'b0, 4'b1110));
    vecs.push_back(nop(1'b0, 4'b0110));
    vecs.push_back(nop(1'b0, 4'b1111));
    vecs.push_back(mk(1'b0, 8'h00, 3'd7, 2'b00, 4'd0, 1'b0, 4'b0000, 1'b1, fc(1)));
    vecs.push_back(nop(1'b0, 4'b0000));
    // Back-to-back repeat, stop raised inside the second frame
    vecs.push_back(mk(1'b1, 8'h15, 3'd4, 2'b01, 4'd0, 1'b0, 4'b1110, 1'b1, 8'd0));
    vecs.push_back(nop(1'b0, 4'b0110));
    vecs.push_back(nop(1'b0, 4'b1110));
    vecs.push_back(nop(1'b0, 4'b0110));
    vecs.push_back(nop(1'b0, 4'b1111));
    vecs.push_back(nop(1'b0, 4'b1110));
    vecs.push_back(nop(1'b1, 4'b0110));
    vecs.push_back(nop(1'b0, 4'b1110));
    vecs.push_back(nop(1'b0, 4'b0110));
    vecs.push_back(nop(1'b0, 4'b1111));
    vecs.push_back(mk(1'b0, 8'h00, 3'd7, 2'b00, 4'd0, 1'b0, 4'b0000, 1'b1, fc(2)));
    // Repeat with gap 3; pattern[2:0] of 8'hA5 is 101. start+stop together must not latch stop.
    vecs.push_back(mk(1'b1, 8'hA5, 3'd2, 2'b10, 4'd3, 1'b1, 4'b1110, 1'b0, 8'd0));
    vecs.push_back(nop(1'b0, 4'b0110));
    vecs.push_back(nop(1'b0, 4'b1111));
    vecs.push_back(nop(1'b0, 4'b0010));
    vecs.push_back(nop(1'b0, 4'b0010));
    vecs.push_back(nop(1'b0, 4'b0010));
    vecs.push_back(nop(1'b0, 4'b1110));
    vecs.push_back(nop(1'b0, 4'b0110));
    vecs.push_back(nop(1'b0, 4'b1111));
    vecs.push_back(nop(1'b0, 4'b0010));
    vecs.push_back(nop(1'b1, 4'b0000));
    vecs.push_back(mk(1'b0, 8'h00, 3'd7, 2'b00, 4'd0, 1'b1, 4'b0000, 1'b1, fc(2)));
    // len 0 back-to-back: frame_done on every bit
    vecs.push_back(mk(1'b1, 8'h01, 3'd0, 2'b01, 4'd0, 1'b0, 4'b1111, 1'b0, 8'd0));
    vecs.push_back(nop(1'b0, 4'b1111));
    vecs.push_back(nop(1'b0, 4'b1111));
    vecs.push_back(nop(1'b1, 4'b0000));
    vecs.push_back(mk(1'b0, 8'h00, 3'd7, 2'b00, 4'd0, 1'b0, 4'b0000, 1'b1, fc(3)));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].st, vecs[i].pat, vecs[i].ln, vecs[i].md, vecs[i].gp, vecs[i].sp);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_outs", i), {28'd0, outs()}, {28'd0, vecs[i].expOut});
      if (vecs[i].chkCnt)
        checkOutput($sformatf("vec%0d_count", i), {24'd0, frame_count}, {24'd0, vecs[i].expCnt});
    end

    // Asynchronous reset on the 3rd bit of an 8-bit frame, then restart from pattern[len]
    patB4 = 8'hB4;
    applyStimulus(1'b1, patB4, 3'd7, 2'b01, 4'd0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("rst_bit1", {28'd0, outs()}, 32'b1110);
    @(posedge clk); #1;
    checkOutput("rst_bit2", {28'd0, outs()}, 32'b0110);
    @(posedge clk); #1;
    checkOutput("rst_bit3", {28'd0, outs()}, 32'b1110);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_async_outs", {28'd0, outs()}, 32'h0);
    checkOutput("rst_async_count", {24'd0, frame_count}, 32'h0);
    @(posedge clk); #1;
    checkOutput("rst_held", {28'd0, outs()}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_released_idle", {28'd0, outs()}, 32'h0);
    applyStimulus(1'b1, patB4, 3'd7, 2'b00, 4'd0, 1'b0);
    for (int b = 7; b >= 0; b--) begin
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput($sformatf("restart_bit%0d", b), {28'd0, outs()},
                  {28'd0, patB4[b], 1'b1, 1'b1, (b == 0)});
    end
    @(posedge clk); #1;
    checkOutput("restart_idle", {28'd0, outs()}, 32'h0);

    // start re-pulsed mid-frame with a different configuration must be ignored
    applyStimulus(1'b1, 8'h15, 3'd4, 2'b00, 4'd0, 1'b0);
    @(posedge clk); #1;
    checkOutput("midstart_bit4", {28'd0, outs()}, 32'b1110);
    applyStimulus(1'b1, 8'hFF, 3'd7, 2'b01, 4'd2, 1'b0);
    @(posedge clk); #1;
    checkOutput("midstart_bit3", {28'd0, outs()}, 32'b0110);
    applyStimulus(1'b0, 8'hFF, 3'd7, 2'b01, 4'd2, 1'b0);
    @(posedge clk); #1;
    checkOutput("midstart_bit2", {28'd0, outs()}, 32'b1110);
    @(posedge clk); #1;
    checkOutput("midstart_bit1", {28'd0, outs()}, 32'b0110);
    @(posedge clk); #1;
    checkOutput("midstart_bit0", {28'd0, outs()}, 32'b1111);
    @(posedge clk); #1;
    checkOutput("midstart_idle", {28'd0, outs()}, 32'h0);

    // Loopback into an overlapping 10101 detector model; stop raised in the third frame
    stream   = 5'b10101;
    detShift = 5'd0;
    detCount = 0;
    firstDet = -1;
    applyStimulus(1'b1, 8'h15, 3'd4, 2'b01, 4'd0, 1'b0);
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stop  = (c == 11);
      checkOutput($sformatf("loop_bit%0d", c), {30'd0, data, valid}, {30'd0, stream[4 - (c % 5)], 1'b1});
      if (valid) begin
        detShift = {detShift[3:0], data};
        if (detShift == 5'b10101) begin
          detCount++;
          if (firstDet < 0) firstDet = c;
        end
      end
    end
    stop = 1'b0;
    for (int k = 0; k < 10 && busy; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("loop_busy_clear", {31'd0, busy}, 32'd0);
    checkOutput("loop_detect_count", detCount, 3);
    checkOutput("loop_first_detect", firstDet, 4);
    @(posedge clk); #1;
    checkOutput("loop_frame_count", {24'd0, frame_count}, {24'd0, fc(3)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
